// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: applies one single-position shift per clock until the requested amount is done.
// Optional carry_out port enabled by defining SHIFT_SEQ_CARRY_EN.
module shift_sequencer #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [AMT_W-1:0] amount,
   input  logic [WIDTH-1:0] din,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dout
`ifdef SHIFT_SEQ_CARRY_EN
   ,
   output logic             carry_out
`endif
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [1:0] OP_PASS = 2'b00;
   localparam logic [1:0] OP_SHL  = 2'b01;
   localparam logic [1:0] OP_SHR  = 2'b10;
   localparam logic [1:0] OP_SAR  = 2'b11;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [WIDTH-1:0] step_work;

`ifdef SHIFT_SEQ_CARRY_EN
   logic carry_q, carry_d;
   logic step_bit;
`endif

   // One single-position step of the latched operation.
   always_comb begin
      step_work = work_q;
`ifdef SHIFT_SEQ_CARRY_EN
      step_bit  = 1'b0;
`endif
      case (op_q)
         OP_SHL: begin
            step_work = {work_q[WIDTH-2:0], 1'b0};
`ifdef SHIFT_SEQ_CARRY_EN
            step_bit  = work_q[WIDTH-1];
`endif
         end
         OP_SHR: begin
            step_work = {1'b0, work_q[WIDTH-1:1]};
`ifdef SHIFT_SEQ_CARRY_EN
            step_bit  = work_q[0];
`endif
         end
         OP_SAR: begin
            step_work = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
`ifdef SHIFT_SEQ_CARRY_EN
            step_bit  = work_q[0];
`endif
         end
         default: step_work = work_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      dout_d  = dout_q;
`ifdef SHIFT_SEQ_CARRY_EN
      carry_d = carry_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               work_d = din;
               cnt_d  = amount;
               op_d   = op;
               // Trivial requests skip SHIFT; result is ready in the next cycle.
               if (op == OP_PASS || amount == '0) begin
                  state_d = DONE;
                  dout_d  = din;
`ifdef SHIFT_SEQ_CARRY_EN
                  carry_d = 1'b0;
`endif
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            work_d = step_work;
            cnt_d  = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
               state_d = DONE;
               dout_d  = step_work;
`ifdef SHIFT_SEQ_CARRY_EN
               carry_d = step_bit;
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         op_q    <= OP_PASS;
         dout_q  <= '0;
`ifdef SHIFT_SEQ_CARRY_EN
         carry_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         dout_q  <= dout_d;
`ifdef SHIFT_SEQ_CARRY_EN
         carry_q <= carry_d;
`endif
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign dout = dout_q;
`ifdef SHIFT_SEQ_CARRY_EN
   assign carry_out = carry_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: vector table, random ops, reset and handshake sequences.
// Carry checks are active when SHIFT_SEQ_CARRY_EN is defined.
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  op;
   logic [3:0]  amount;
   logic [15:0] din;
   logic        busy;
   logic        done;
   logic [15:0] dout;
`ifdef SHIFT_SEQ_CARRY_EN
   logic        carry_out;
`endif

   always #5 clk = ~clk;

   shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .op        (op),
      .amount    (amount),
      .din       (din),
      .busy      (busy),
      .done      (done),
`ifdef SHIFT_SEQ_CARRY_EN
      .carry_out (carry_out),
`endif
      .dout      (dout)
   );

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  amt;
      logic [15:0] din;
      logic [15:0] exp;
      logic        exp_c;
      int          lat;
   } vec_t;

   typedef struct {
      logic [15:0] d;
      logic        c;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t tbl[10];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard side: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done with empty scoreboard (t=%0t)", $time);
         end else begin
            mon_e = sb.pop_front();
            check("dout", {16'h0, dout}, {16'h0, mon_e.d});
`ifdef SHIFT_SEQ_CARRY_EN
            check("carry_out", {31'h0, carry_out}, {31'h0, mon_e.c});
`endif
         end
      end
   end

   function automatic vec_t model(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d);
      vec_t v;
      int   n;
      n       = int'(a);
      v.op    = o;
      v.amt   = a;
      v.din   = d;
      v.exp   = d;
      v.exp_c = 1'b0;
      v.lat   = 1;
      if (o != 2'b00 && n != 0) begin
         v.lat = n + 1;
         case (o)
            2'b01: begin v.exp = d << n; v.exp_c = d[16-n]; end
            2'b10: begin v.exp = d >> n; v.exp_c = d[n-1]; end
            default: begin v.exp = 16'($signed(d) >>> n); v.exp_c = d[n-1]; end
         endcase
      end
      return v;
   endfunction

   task automatic run_op(input vec_t v);
      logic [15:0] prev;
      int          n;
      exp_t        e;
      @(negedge clk);
      op     = v.op;
      amount = v.amt;
      din    = v.din;
      start  = 1'b1;
      e.d    = v.exp;
      e.c    = v.exp_c;
      sb.push_back(e);
      prev   = dout;
      @(negedge clk);
      start  = 1'b0;
      n = 1;
      while (done !== 1'b1 && n < 40) begin
         check("busy_shift", {31'h0, busy}, 32'h1);
         check("dout_stable", {16'h0, dout}, {16'h0, prev});
         @(negedge clk);
         n++;
      end
      check("busy_done", {31'h0, busy}, 32'h1);
      check("latency", n, v.lat);
      if (n >= 40) sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          ndone;
      int          n;
      logic [15:0] prev;
      exp_t        e;

      tbl[0] = '{2'b01, 4'd4,  16'h0F0F, 16'hF0F0, 1'b0, 5};
      tbl[1] = '{2'b10, 4'd3,  16'h8001, 16'h1000, 1'b0, 4};
      tbl[2] = '{2'b11, 4'd3,  16'h8001, 16'hF000, 1'b0, 4};
      tbl[3] = '{2'b00, 4'd7,  16'hABCD, 16'hABCD, 1'b0, 1};
      tbl[4] = '{2'b01, 4'd0,  16'h1234, 16'h1234, 1'b0, 1};
      tbl[5] = '{2'b11, 4'd15, 16'h8000, 16'hFFFF, 1'b0, 16};
      tbl[6] = '{2'b01, 4'd15, 16'hFFFF, 16'h8000, 1'b1, 16};
      tbl[7] = '{2'b10, 4'd15, 16'hFFFF, 16'h0001, 1'b1, 16};
      tbl[8] = '{2'b10, 4'd1,  16'h0003, 16'h0001, 1'b1, 2};
      tbl[9] = '{2'b11, 4'd4,  16'h7FF0, 16'h07FF, 1'b0, 5};

      reset_n = 1'b0;
      start   = 1'b0;
      op      = 2'b00;
      amount  = 4'd0;
      din     = 16'h0;
      #1;
      check("reset_busy", {31'h0, busy}, 32'h0);
      check("reset_done", {31'h0, done}, 32'h0);
      check("reset_dout", {16'h0, dout}, 32'h0);
`ifdef SHIFT_SEQ_CARRY_EN
      check("reset_carry", {31'h0, carry_out}, 32'h0);
`endif
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++) run_op(tbl[i]);

      for (int i = 0; i < 8; i++) begin
         run_op(model(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'($urandom)));
      end

      // Reset three cycles into a long left shift: abandon with no done.
      @(negedge clk);
      op = 2'b01; amount = 4'd8; din = 16'h00FF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("busy_before_reset", {31'h0, busy}, 32'h1);
      #2 reset_n = 1'b0;
      #1;
      check("midreset_busy", {31'h0, busy}, 32'h0);
      check("midreset_done", {31'h0, done}, 32'h0);
      check("midreset_dout", {16'h0, dout}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      check("no_done_after_reset", ndone, 0);

      run_op('{2'b00, 4'd0, 16'h5A5A, 16'h5A5A, 1'b0, 1});

      // Start held high with changing operands during an amount-5 op.
      @(negedge clk);
      op = 2'b01; amount = 4'd5; din = 16'h00F1; start = 1'b1;
      e.d = 16'h1E20; e.c = 1'b0;
      sb.push_back(e);
      prev = dout;
      @(negedge clk);
      n = 1;
      while (done !== 1'b1 && n < 20) begin
         check("hs_dout_stable", {16'h0, dout}, {16'h0, prev});
         op = 2'($urandom); amount = 4'($urandom); din = 16'($urandom);
         @(negedge clk);
         n++;
      end
      check("hs_latency", n, 6);
      op = 2'b10; amount = 4'd1; din = 16'h8000;
      e.d = 16'h4000; e.c = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      check("hs_idle_after_done", {31'h0, busy}, 32'h0);
      @(negedge clk);
      start = 1'b0;
      check("hs_b2b_accepted", {31'h0, busy}, 32'h1);
      n = 1;
      while (done !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("hs_b2b_latency", n, 2);
      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
